mealy_fsm: RTL and testbench



---
 rtl/mealy_fsm.sv | 54 +++++
 tb/tb_mealy_fsm.sv | 117 +++++++++++
 2 files changed

// File: rtl/mealy_fsm.sv
// Overlapping "110" serial sequence detector.
// The detect flag is combinational from the current state and the current input bit.
module mealy_fsm (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    // state    | meaning
    // S0       | no useful prefix seen
    // S1       | last bit was "1"
    // S2       | last bits were "11"
    // S_UNUSED | illegal encoding, recovers to S0
    typedef enum logic [1:0] {
        S0       = 2'd0,
        S1       = 2'd1,
        S2       = 2'd2,
        S_UNUSED = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S0;
        out     = 1'b0;
        case (state_q)
            S0: begin
                state_d = in ? S1 : S0;
            end
            S1: begin
                state_d = in ? S2 : S0;
            end
            S2: begin
                // A run of 1s keeps the "11" prefix alive.
                state_d = in ? S2 : S0;
                out     = ~in & ~reset;
            end
            default: begin
                state_d = S0;
            end
        endcase
    end

endmodule

// File: tb/tb_mealy_fsm.sv
// Bench for the "110" detector: directed sequences plus random bits with occasional
// resets, checked against a model that looks at the raw bit history since reset.
module tb_mealy_fsm;

    logic clk;
    logic reset;
    logic in;
    logic out;

    int n_checks;
    int n_fail;

    // Bits received since the last reset, newest in bit 0, and how many are valid.
    logic [1:0] hist;
    int         n_bits;

    mealy_fsm dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one bit (and reset) for one clock, check the flag mid-cycle,
    // then advance the model at the rising edge.
    task automatic step(input string tag, input logic r, input logic b);
        logic exp;
        @(negedge clk);
        reset = r;
        in    = b;
        #1;
        exp = !r && !b && (n_bits >= 2) && (hist == 2'b11);
        check_bit(tag, out, exp);
        @(posedge clk);
        if (r) begin
            n_bits = 0;
            hist   = 2'b00;
        end else begin
            hist   = {hist[0], b};
            n_bits = (n_bits < 2) ? n_bits + 1 : 2;
        end
    endtask

    task automatic run_bits(input string tag, input logic [15:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            step(tag, 1'b0, bits[i]);
        end
    endtask

    int pulses;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        hist     = 2'b00;
        n_bits   = 0;
        reset    = 1'b1;
        in       = 1'b0;

        step("reset_in0", 1'b1, 1'b0);
        step("reset_in0_b", 1'b1, 1'b0);

        run_bits("seq_10", 16'b10, 2);
        run_bits("seq_110", 16'b110, 3);
        run_bits("seq_1110", 16'b1110, 4);
        run_bits("seq_110110", 16'b110110, 6);
        run_bits("seq_11011", 16'b11011, 5);
        step("seq_11010", 1'b0, 1'b0);

        // Reset while holding "11" with in=0 must mask the flag and drop the prefix.
        run_bits("pre_rst_11", 16'b11, 2);
        step("rst_in_s2", 1'b1, 1'b0);
        step("post_rst_0", 1'b0, 1'b0);
        run_bits("post_rst_110", 16'b110, 3);

        // Reset asserted with "11" pending and in=1, then release straight into a '0'.
        run_bits("pre_rst2_11", 16'b11, 2);
        step("rst_in_s2_in1", 1'b1, 1'b1);
        step("post_rst2_0", 1'b0, 1'b0);

        // Pulse count for back-to-back overlap, counted independently of step().
        step("sync_rst", 1'b1, 1'b0);
        pulses = 0;
        for (int i = 5; i >= 0; i--) begin
            logic [5:0] pat;
            pat = 6'b110110;
            @(negedge clk);
            reset = 1'b0;
            in    = pat[i];
            #1;
            if (out === 1'b1) pulses++;
            @(posedge clk);
            hist   = {hist[0], pat[i]};
            n_bits = (n_bits < 2) ? n_bits + 1 : 2;
        end
        check_bit("pulse_count_110110", (pulses == 2), 1'b1);

        for (int k = 0; k < 2000; k++) begin
            step("random", ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
